// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, one bit per clock, LSB first.
// Optional signed-overflow flag on port ovf when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_s, cell_c, last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    cell_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    cell_c   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    last_bit = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = WIDTH'({cell_s, sum_q} >> 1);
        carry_d = cell_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ cell_c;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances.
// Overflow checks are compiled in only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 0, out_ready8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;

  logic       in_valid1 = 0, out_ready1 = 0, cin1 = 0;
  logic [0:0] a1 = 0, b1 = 0;
  logic       in_ready1, out_valid1, cout1, busy1;
  logic [0:0] sum1;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic accept8(input logic [7:0] av, input logic [7:0] bv, input logic c);
    a8 = av; b8 = bv; cin8 = c; in_valid8 = 1;
    @(posedge clk); #1;
    in_valid8 = 0;
  endtask

  // Edges counted after the accept edge until out_valid; 40 on timeout.
  task automatic wait_out8(output int n);
    n = 0;
    while (!out_valid8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout8); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf8); end
`endif
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_ff_plus_01;
    int n;
    out_ready8 = 1;
    accept8(8'hFF, 8'h01, 1'b0);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy8); end
    checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL run_in_ready got %b want 0", in_ready8); end
    wait_out8(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL ff01_latency got %0d want 8", n); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL ff01_sum got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b1) begin errors++; $display("FAIL ff01_cout got %b want 1", cout8); end
    @(posedge clk); #1;
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL ff01_in_ready_after got %b want 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL ff01_out_valid_after got %b want 0", out_valid8); end
    out_ready8 = 0;
  endtask

  task automatic test_in_valid_held;
    int n, seen;
    out_ready8 = 0;
    a8 = 8'h3C; b8 = 8'hA5; cin8 = 1; in_valid8 = 1;
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'h00; cin8 = 0;
    wait_out8(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL held_latency got %0d want 8", n); end
    checks++; if (sum8 !== 8'hE2) begin errors++; $display("FAIL held_sum got %h want e2", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL held_cout got %b want 0", cout8); end
    in_valid8 = 0; out_ready8 = 1;
    @(posedge clk); #1;
    out_ready8 = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL held_extra_results got %0d want 0", seen); end
  endtask

  task automatic test_backpressure;
    int n, seen;
    out_ready8 = 0;
    accept8(8'h55, 8'h0F, 1'b0);
    wait_out8(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_latency got %0d want 8", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid8); end
      checks++; if (sum8 !== 8'h64) begin errors++; $display("FAIL bp_sum cyc %0d got %h want 64", i, sum8); end
      checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL bp_cout cyc %0d got %b want 0", i, cout8); end
      checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready8); end
      @(posedge clk); #1;
    end
    out_ready8 = 1;
    @(posedge clk); #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", out_valid8); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid8) seen++;
      @(posedge clk); #1;
    end
    out_ready8 = 0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL bp_second_transfer got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    out_ready8 = 1;
    accept8(8'h55, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %b want 0", busy8); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL rstrun_in_ready got %b want 1", in_ready8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL rstrun_sum got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL rstrun_cout got %b want 0", cout8); end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL rstrun_in_ready_after got %b want 1", in_ready8); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen++;
      @(posedge clk); #1;
    end
    out_ready8 = 0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstrun_out_valid got %0d want 0", seen); end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf;
    int n;
    out_ready8 = 0;
    accept8(8'h7F, 8'h01, 1'b0);
    wait_out8(n);
    checks++; if (sum8 !== 8'h80) begin errors++; $display("FAIL ovf1_sum got %h want 80", sum8); end
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got %b want 1", ovf8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL ovf1_cout got %b want 0", cout8); end
    out_ready8 = 1; @(posedge clk); #1; out_ready8 = 0;
    accept8(8'hFF, 8'h01, 1'b0);
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_accept got %b want 0", ovf8); end
    wait_out8(n);
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got %b want 0", ovf8); end
    checks++; if (cout8 !== 1'b1) begin errors++; $display("FAIL ovf2_cout got %b want 1", cout8); end
    out_ready8 = 1; @(posedge clk); #1; out_ready8 = 0;
  endtask
`endif

  task automatic test_width1;
    int n;
    logic [1:0] exp;
    out_ready1 = 0;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      exp = 2'(a1) + 2'(b1) + 2'(cin1);
      in_valid1 = 1;
      @(posedge clk); #1;
      in_valid1 = 0;
      n = 0;
      while (!out_valid1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL w1_latency combo %0d got %0d want 1", i, n); end
      checks++; if ({cout1, sum1} !== exp) begin errors++; $display("FAIL w1_sum combo %0d got %b want %b", i, {cout1, sum1}, exp); end
      out_ready1 = 1;
      @(posedge clk); #1;
      out_ready1 = 0;
    end
  endtask

  initial begin
    test_reset;
    test_ff_plus_01;
    test_in_valid_held;
    test_backpressure;
    test_reset_mid_run;
`ifdef SERIAL_ADD_OVF_EN
    test_ovf;
`endif
    test_width1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
